whack_game_core: RTL
====================

# whack_game_core

Parametrised game-logic core for the stomp-pad whack-a-mole system. It generalises the single-mole game FSM: it supports NUM_PADS pads and up to MAX_MOLES simultaneously active moles, each with its own tick countdown. It sits between the debounced pad inputs, mole request source and random generator on one side, and the display and sound modules on the other.

## Interface
- NUM_PADS, 8: number of stomp pads/mole locations (2..16)
- MAX_MOLES, 2: concurrent mole slots (1..4)
- MOLE_TICKS, 2: tick-enables a mole stays up (1..15)
- START_TICKS, 3: ticks between start and play
- OVER_TICKS, 3: ticks in game-over before returning to idle
- LIVES_INIT, 3: lives at game start (1..7)
- SCORE_W, 8: score width
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle enable from the divider
- start  in  1  start request; level, acted on in IDLE only
- request_mole  in  1  one-cycle mole request
- rand_loc  in  $clog2(NUM_PADS)  candidate location, sampled with request_mole
- pads  in  NUM_PADS  debounced pad levels, active-high
- game_state  out  2  IDLE=0, ARMED=1, PLAY=2, OVER=3
- mole_map  out  NUM_PADS  bit p set = mole up at pad p
- lives  out  3  remaining lives
- score  out  SCORE_W  moles whacked, saturating
- hit_pulse  out  1  one cycle per cycle with at least one hit
- miss_pulse  out  1  one cycle per cycle with a life lost
- drop_pulse  out  1  request rejected

## Operation
- Reset state: game_state=IDLE, mole_map=0, lives=LIVES_INIT, score=0, all pulses 0, all slots free, pad history=0.
- IDLE: lives=LIVES_INIT, score=0. start=1 moves to ARMED and loads the phase counter with START_TICKS.
- ARMED: counter decrements on tick. At 0 the block moves to PLAY.
- PLAY, allocation: request_mole with rand_loc<NUM_PADS, location free and a slot free loads the lowest-index free slot: loc=rand_loc, timer=MOLE_TICKS. Otherwise drop_pulse=1 and nothing changes. request_mole is ignored outside PLAY.
- PLAY, pad edges: rise = pads & ~pads_q.
  - A rising pad with a mole on it is a hit: its slot is freed and score increments by the number of hits that cycle, saturating at all-ones.
  - A rising pad with no mole is a misstep.
- PLAY, expiry: on tick, each active slot decrements. A slot with timer==1 frees and counts as an expiry. A hit and an expiry on the same slot in the same cycle count as a hit.
- Life loss: any expiry or counted misstep in a cycle costs exactly one life, with lives floored at 0. miss_pulse=1 that cycle.
- lives reaching 0 moves the block to OVER: all slots are cleared and the counter is loaded with OVER_TICKS. At 0 ticks it returns to IDLE.
- Freeing and allocating the same location in one cycle: the allocation is accepted.
- reset mid-game: immediate return to reset state on the next edge.

## Timing
- All outputs are registered. Inputs sampled at edge N produce outputs visible after edge N (1-cycle latency).
- mole_map reflects slot state in the same cycle as the slot change.
- Pulses last exactly one cycle and never stretch.
- ARMED lasts START_TICKS tick-enables. A tick coinciding with the entry edge is not counted.
- start held through OVER into IDLE restarts the game on the cycle after IDLE is entered.

## Configuration
- WHACK_MISSTEP_PENALTY_EN defined: a misstep in PLAY costs a life.
- Not defined: missteps are ignored, and only expiries cost lives.

## Structure
- whack_pkg holds:
  - the game_state enum and its encoding
  - the LOC_W function ($clog2 wrapper)
  - the lives width constant
- Sub-module mole_slot, instantiated MAX_MOLES times. Each instance holds active, loc and timer, with load, clear and tick ports and an expire output.
- The top level does arbitration, edge detection, counters and the phase FSM.

## Test plan
- Reset, then start=1 for one cycle, then 3 ticks: ARMED for exactly 3 ticks, then game_state=2, lives=3, score=0.
- PLAY, request_mole with rand_loc=5, then pads[5] rises 2 cycles later: mole_map=8'h20, then hit_pulse=1, score=1, mole_map=0.
- Mole at loc 2 left alone for 2 ticks: on the 2nd tick miss_pulse=1, lives=2, mole_map=0.
- MAX_MOLES=2: requests to 1 and 3 are accepted, a request to 6 gives drop_pulse; then a request to 1 while 1 is up gives drop_pulse.
- pads[0] rises with no mole: with the macro defined lives 3→2; without it lives stay at 3.
- Three expiries: lives=0, then OVER with mole_map=0, then IDLE after 3 ticks. A further reset mid-PLAY returns all outputs to reset values.

Source files
------------

// File: rtl/whack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | whack_pkg                                                            |
// | Shared types and constants for the whack-a-mole game core.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package whack_pkg;

   // Phase encoding is visible on the game_state port, so values are fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } game_state_t;

   localparam int LIVES_W = 3;   // lives output width (LIVES_INIT up to 7)
   localparam int TIMER_W = 4;   // per-mole tick countdown (MOLE_TICKS up to 15)
   localparam int PHASE_W = 8;   // ARMED / OVER phase counter

   // Location width for n pads; never narrower than one bit.
   function automatic int LOC_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mole_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mole_slot                                                            |
// | One mole slot: active flag, pad location and tick countdown.         |
// | load has priority over clear, clear over the tick countdown.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mole_slot
   import whack_pkg::*;
#(
   parameter int LOC_BITS   = 3,
   parameter int MOLE_TICKS = 2
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [LOC_BITS-1:0] load_loc,
   input  logic                clear,
   input  logic                tick,
   output logic                active,
   output logic [LOC_BITS-1:0] loc,
   output logic                expire
);

   logic [TIMER_W-1:0] timer;

   // The slot times out on the tick that finds one tick remaining.
   assign expire = active & tick & (timer == TIMER_W'(1));

   // Slot state: a load re-arms even a slot that is expiring this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         loc    <= '0;
         timer  <= '0;
      end else if (load) begin
         active <= 1'b1;
         loc    <= load_loc;
         timer  <= TIMER_W'(MOLE_TICKS);
      end else if (clear) begin
         active <= 1'b0;
      end else if (tick && active) begin
         if (timer == TIMER_W'(1)) begin
            active <= 1'b0;
         end else begin
            timer <= timer - TIMER_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/whack_game_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | whack_game_core                                                      |
// | Multi-mole game core: slot arbitration, pad edge detection, score,   |
// | lives and the IDLE/ARMED/PLAY/OVER phase machine.                    |
// | Build option: WHACK_MISSTEP_PENALTY_EN - a rising pad with no mole   |
// | costs a life in PLAY; otherwise such missteps are ignored.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module whack_game_core
   import whack_pkg::*;
#(
   parameter int NUM_PADS    = 8,
   parameter int MAX_MOLES   = 2,
   parameter int MOLE_TICKS  = 2,
   parameter int START_TICKS = 3,
   parameter int OVER_TICKS  = 3,
   parameter int LIVES_INIT  = 3,
   parameter int SCORE_W     = 8
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tick,
   input  logic                          start,
   input  logic                          request_mole,
   input  logic [LOC_W(NUM_PADS)-1:0]    rand_loc,
   input  logic [NUM_PADS-1:0]           pads,
   output logic [1:0]                    game_state,
   output logic [NUM_PADS-1:0]           mole_map,
   output logic [LIVES_W-1:0]            lives,
   output logic [SCORE_W-1:0]            score,
   output logic                          hit_pulse,
   output logic                          miss_pulse,
   output logic                          drop_pulse
);

   localparam int            LW         = LOC_W(NUM_PADS);
   localparam logic [LW:0]   NUM_PADS_V = (LW+1)'(NUM_PADS);

   game_state_t          state_q, state_d;
   logic [PHASE_W-1:0]   cnt_q, cnt_d;
   logic [LIVES_W-1:0]   lives_d, lives_next;
   logic [SCORE_W-1:0]   score_d;
   logic [SCORE_W:0]     score_sum;
   logic [NUM_PADS-1:0]  pads_q, rise;
   logic                 hit_d, miss_d, drop_d;

   logic [MAX_MOLES-1:0] slot_active, slot_expire, slot_hit, slot_load, slot_clear, slot_freeing;
   logic [LW-1:0]        slot_loc [MAX_MOLES];
   logic                 slot_tick;

   logic                 in_play, expiry_any, lose_life, go_over, alloc_ok;
   logic                 slot_found, loc_busy;
   logic [2:0]           hit_cnt;
   int                   sel;

   assign in_play      = (state_q == ST_PLAY);
   assign rise         = pads & ~pads_q;
   assign slot_tick    = tick & in_play;
   assign slot_freeing = slot_hit | slot_expire;
   // A hit on a slot that also times out this cycle counts only as a hit.
   assign expiry_any   = |(slot_expire & ~slot_hit);

`ifdef WHACK_MISSTEP_PENALTY_EN
   logic misstep;
   assign misstep   = in_play & |(rise & ~mole_map);
   assign lose_life = in_play & (expiry_any | misstep);
`else
   assign lose_life = in_play & expiry_any;
`endif

   assign lives_next = (lives != '0) ? lives - LIVES_W'(1) : lives;
   assign go_over    = lose_life & (lives_next == '0);

   // Request accepted when the pad is valid, not held by a surviving mole, and a slot is (becoming) free.
   assign alloc_ok   = in_play & request_mole & ({1'b0, rand_loc} < NUM_PADS_V) & ~loc_busy & slot_found;

   assign score_sum  = {1'b0, score} + (SCORE_W+1)'(hit_cnt);

   // Map of raised moles, hit count, and lowest-index slot free after this cycle's releases.
   always_comb begin
      mole_map   = '0;
      hit_cnt    = '0;
      slot_found = 1'b0;
      loc_busy   = 1'b0;
      sel        = 0;
      for (int s = MAX_MOLES - 1; s >= 0; s--) begin
         if (slot_active[s]) begin
            mole_map[slot_loc[s]] = 1'b1;
         end
         hit_cnt = hit_cnt + {2'b00, slot_hit[s]};
         if (slot_active[s] && !slot_freeing[s] && (slot_loc[s] == rand_loc)) begin
            loc_busy = 1'b1;
         end
         if (!slot_active[s] || slot_freeing[s]) begin
            slot_found = 1'b1;
            sel        = s;
         end
      end
   end

   for (genvar g = 0; g < MAX_MOLES; g++) begin : g_slot
      assign slot_hit[g]   = in_play & slot_active[g] & rise[slot_loc[g]];
      assign slot_load[g]  = alloc_ok & ~go_over & (sel == g);
      assign slot_clear[g] = slot_hit[g] | go_over;

      mole_slot #(
         .LOC_BITS   (LW),
         .MOLE_TICKS (MOLE_TICKS)
      ) u_slot (
         .clk      (clk),
         .reset    (reset),
         .load     (slot_load[g]),
         .load_loc (rand_loc),
         .clear    (slot_clear[g]),
         .tick     (slot_tick),
         .active   (slot_active[g]),
         .loc      (slot_loc[g]),
         .expire   (slot_expire[g])
      );
   end

   // Phase machine next state plus score, lives and event pulses.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lives_d = lives;
      score_d = score;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      drop_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            lives_d = LIVES_W'(LIVES_INIT);
            score_d = '0;
            if (start) begin
               state_d = ST_ARMED;
               cnt_d   = PHASE_W'(START_TICKS);
            end
         end
         ST_ARMED: begin
            if (cnt_q == '0) begin
               state_d = ST_PLAY;
            end else if (tick) begin
               cnt_d = cnt_q - PHASE_W'(1);
               if (cnt_q == PHASE_W'(1)) state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            hit_d   = (hit_cnt != '0);
            drop_d  = request_mole & ~alloc_ok;
            if (lose_life) begin
               miss_d  = 1'b1;
               lives_d = lives_next;
            end
            if (go_over) begin
               state_d = ST_OVER;
               cnt_d   = PHASE_W'(OVER_TICKS);
            end
         end
         default: begin
            if (cnt_q == '0 || (tick && cnt_q == PHASE_W'(1))) begin
               state_d = ST_IDLE;
               lives_d = LIVES_W'(LIVES_INIT);
               score_d = '0;
            end
            if (tick && cnt_q != '0) cnt_d = cnt_q - PHASE_W'(1);
         end
      endcase
   end

   // Registered game state, counters and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lives      <= LIVES_W'(LIVES_INIT);
         score      <= '0;
         pads_q     <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         drop_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lives      <= lives_d;
         score      <= score_d;
         pads_q     <= pads;
         hit_pulse  <= hit_d;
         miss_pulse <= miss_d;
         drop_pulse <= drop_d;
      end
   end

   assign game_state = state_q;

endmodule
`default_nettype wire
